// File: rtl/alu_decoder_mc.sv
// ALU control decoder with a multi-cycle HI/LO multiply (and optional divide) unit.
// Define ALU_DECODER_MC_DIVIDE_EN to include the restoring divider and DIV/DIVU.
module alu_decoder_mc #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid,
  input  logic [1:0]        aluop,
  input  logic [5:0]        funct,
  input  logic [WIDTH-1:0]  srca,
  input  logic [WIDTH-1:0]  srcb,
  input  logic              flush,
  output logic [CTRL_W-1:0] alucontrol,
  output logic              illegal,
  output logic              busy,
  output logic              stall,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo
);
  // Handshake: an op is taken on the edge where valid & aluop=10 & mult/div funct
  // & IDLE & !flush; while busy, any HI/LO-class op sees stall=1 and must be held.
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] den_q, den_d, sh_q, sh_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic             neg_q, neg_d;
`ifdef ALU_DECODER_MC_DIVIDE_EN
  logic             div_q, div_d, rneg_q, rneg_d;
`endif

  logic [3:0] ctrl;
  logic       md_op, mf_op, accept, sgn;

  always_comb begin
    ctrl    = 4'b0010;
    illegal = 1'b0;
    md_op   = 1'b0;
    mf_op   = 1'b0;
    case (aluop)
      2'b00: ctrl = 4'b0010;
      2'b01: ctrl = 4'b0110;
      2'b11: ctrl = 4'b0111;
      default: begin
        case (funct)
          6'b100100: ctrl = 4'b0000;
          6'b100101: ctrl = 4'b0001;
          6'b100000, 6'b100001: ctrl = 4'b0010;
          6'b100010, 6'b100011: ctrl = 4'b0110;
          6'b100110: ctrl = 4'b0011;
          6'b100111: ctrl = 4'b0100;
          6'b101010: ctrl = 4'b0111;
          6'b101011: ctrl = 4'b0101;
          6'b010000, 6'b010010: mf_op = 1'b1;
          6'b011000, 6'b011001: md_op = 1'b1;
`ifdef ALU_DECODER_MC_DIVIDE_EN
          6'b011010, 6'b011011: md_op = 1'b1;
`endif
          default: begin
            ctrl    = 4'b0000;
            illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign alucontrol = CTRL_W'(ctrl);
  assign busy       = (state_q == BUSY);
  assign stall      = valid && (aluop == 2'b10) && (md_op || mf_op) && busy;
  assign accept     = valid && (aluop == 2'b10) && md_op && (state_q == IDLE) && !flush;
  assign sgn        = ~funct[0];
  assign hi         = hi_q;
  assign lo         = lo_q;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  logic [WIDTH:0]     sum, acc_n;
  logic [WIDTH-1:0]   sh_n, hi_res, lo_res;
  logic [2*WIDTH-1:0] prod, prod_s;
`ifdef ALU_DECODER_MC_DIVIDE_EN
  logic [WIDTH:0]     shifted, trial;
`endif

  // One iteration of the datapath; the last iteration's result feeds HI/LO directly.
  always_comb begin
    sum   = acc_q + (sh_q[0] ? {1'b0, den_q} : '0);
    acc_n = {1'b0, sum[WIDTH:1]};
    sh_n  = {sum[0], sh_q[WIDTH-1:1]};
`ifdef ALU_DECODER_MC_DIVIDE_EN
    shifted = {acc_q[WIDTH-1:0], sh_q[WIDTH-1]};
    trial   = shifted - {1'b0, den_q};
    if (div_q) begin
      if (!trial[WIDTH]) begin
        acc_n = trial;
        sh_n  = {sh_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = shifted;
        sh_n  = {sh_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
    prod   = {acc_n[WIDTH-1:0], sh_n};
    prod_s = neg_q ? -prod : prod;
    hi_res = prod_s[2*WIDTH-1:WIDTH];
    lo_res = prod_s[WIDTH-1:0];
`ifdef ALU_DECODER_MC_DIVIDE_EN
    if (div_q) begin
      // Zero divisor: quotient magnitude is all ones and the remainder is |srca|,
      // which re-signs back to srca; neg_q is cleared at accept for this case.
      lo_res = neg_q ? -sh_n : sh_n;
      hi_res = rneg_q ? -acc_n[WIDTH-1:0] : acc_n[WIDTH-1:0];
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    den_d   = den_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef ALU_DECODER_MC_DIVIDE_EN
    div_d   = div_q;
    rneg_d  = rneg_q;
`endif
    if (state_q == IDLE) begin
      if (accept) begin
        state_d = BUSY;
        cnt_d   = '0;
        den_d   = mag(srcb, sgn);
        sh_d    = mag(srca, sgn);
        acc_d   = '0;
        neg_d   = sgn && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
`ifdef ALU_DECODER_MC_DIVIDE_EN
        div_d   = funct[1];
        rneg_d  = sgn && srca[WIDTH-1];
        if (funct[1]) neg_d = sgn && (srca[WIDTH-1] ^ srcb[WIDTH-1]) && (|srcb);
`endif
      end
    end else if (flush) begin
      state_d = IDLE;
    end else begin
      cnt_d = cnt_q + CW'(1);
      acc_d = acc_n;
      sh_d  = sh_n;
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = IDLE;
        hi_d    = hi_res;
        lo_d    = lo_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      den_q   <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef ALU_DECODER_MC_DIVIDE_EN
      div_q   <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      den_q   <= den_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef ALU_DECODER_MC_DIVIDE_EN
      div_q   <= div_d;
      rneg_q  <= rneg_d;
`endif
    end
  end
endmodule
